ahb_uart_tx: RTL
================

# ahb_uart_tx

AHB-Lite slave UART transmitter on the data-side bus, beside the dcache and GPIO slaves on an AHB_Bus slave port. It holds an 8-entry transmit FIFO written by the core's load/store port. It serialises bytes as 8N1 frames on a single `tx` pin at a programmable baud divisor. Status and divisor registers are readable, so firmware can poll before writing.

## Interface
- `START_ADDR`, default 32'h8003_0000: base address; register offset = `haddr - START_ADDR`, decoded on bits [3:2]
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, 2..16
- `DIV_RESET`, default 16'd868: bit period in HCLK cycles after reset (100 MHz / 115200)

Ports:
- `HCLK` in 1: sole clock, rising edge
- `HRESETn` in 1: reset, asynchronous, active-low
- `haddr` in 32: AHB address
- `hwdata` in 32: AHB write data, data phase
- `hrdata` out 32: AHB read data, data phase
- `hwrite` in 1: 1 = write
- `hsel` in 1: slave select from bus decoder
- `htrans` in 2: transfer type; bit 1 set = NONSEQ/SEQ
- `hsize`, `hburst`, `hprot`, `hmastlock` in 3/3/4/1: accepted, ignored
- `hready` out 1: always 1 (zero wait state)
- `hresp` out 1: always 0 (OKAY)
- `tx` out 1: serial output, idle high

## Operation
- Transfer is valid when `hsel & htrans[1]` in an address phase. Offset and `hwrite` are registered there and acted on in the following data phase.
- Registers:
  - 0x0 DATA: write pushes `hwdata[7:0]`; read returns 0.
  - 0x4 STATUS: read-only. Bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky), bits[8:4] FIFO count; other bits 0.
  - 0x8 BAUD: `[15:0]` bit period in cycles; written values <2 are stored as 2.
  - 0xC: reads 0, writes ignored.
- A DATA write while full (count==FIFO_DEPTH with no pop that cycle) is dropped and sets overflow. A STATUS read clears overflow at the end of its data phase; a simultaneous set wins.
- A push while full in the same cycle as a pop is accepted; the count is unchanged.
- Shifter FSM:
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register, latch the current BAUD, go to START.
  - START: `tx`=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one period each; a 3-bit index counts 0..7.
  - STOP: `tx`=1 for one period. At the end, if FIFO is non-empty, pop and go directly to START (no idle gap); else IDLE.
- Bit-period counter loads latched BAUD−1 and counts down to 0. A BAUD write mid-frame takes effect at the next frame.
- FIFO: circular buffer with wrapping read/write pointers and a count register (avoids full/empty ambiguity).

## Timing
- Reset values (async assert): `tx`=1, `hrdata`=0, `hready`=1, `hresp`=0, FIFO empty, overflow=0, BAUD=DIV_RESET, FSM IDLE.
- Write: address phase in cycle N, `hwdata` sampled at the end of N+1, FIFO count increments after edge N+1.
- Read: `hrdata` is combinational from registered offset/state during data phase N+1. STATUS reflects state as of the start of N+1.
- From an empty idle state, a push completing at edge N+1 produces `tx` falling after edge N+2 (pop at N+2).
- Frame length: exactly 10×BAUD cycles. Busy=1 from the pop edge until the STOP period completes with the FIFO empty.
- Reset mid-frame: `tx` returns high immediately, FIFO contents are lost, and no partial frame resumes after release.

## Test plan
- Reset with BAUD default; write 0x55 to DATA -> `tx` low for 868 cycles, then bits 1,0,1,0,1,0,1,0 each 868 cycles, stop high; STATUS then reads 0x002 (empty).
- Write BAUD=1 -> reads back 2. Write 0xA5 -> frame is 20 cycles with `tx` pattern 0,1,0,1,0,0,1,0,1,1.
- BAUD=4, write 9 bytes back-to-back -> first popped immediately, all 8 remaining held (STATUS count 8, full=1), none dropped. A 10th write while full drops -> overflow=1; next STATUS read shows bit3, following read shows bit3=0.
- Write 3 bytes at BAUD=4 -> frames contiguous (stop bit directly followed by start bit), total 120 cycles busy, then STATUS=0x002.
- Change BAUD from 4 to 8 mid-frame -> current frame stays 40 cycles, next frame 80 cycles.
- Assert HRESETn low mid-data-bit with 3 bytes queued -> `tx`=1 asynchronously; after release STATUS=0x002, BAUD=868, and no further frames.

Source files
------------

// File: rtl/ahb_uart_tx.sv
// ahb_uart_tx: AHB-Lite slave UART transmitter with a small transmit FIFO.
//
// Bytes written to DATA are queued in a circular FIFO and shifted out on tx as
// 8N1 frames (start, 8 data bits LSB first, stop). The bit period comes from
// the BAUD register and is sampled when each frame starts.
//
// Register map (offset = haddr - START_ADDR, decoded on bits [3:2]):
//   0x0 DATA   : write pushes hwdata[7:0]; reads 0
//   0x4 STATUS : {count[8:4], overflow[3], busy[2], empty[1], full[0]}
//   0x8 BAUD   : [15:0] bit period in HCLK cycles, minimum 2
//   0xC        : reads 0, writes ignored
//
// Ports:
//   HCLK, HRESETn            : clock, asynchronous active-low reset
//   haddr, hwdata, hwrite    : AHB address / write data / direction
//   hsel, htrans             : AHB slave select / transfer type
//   hsize, hburst, hprot,
//   hmastlock                : accepted, ignored
//   hrdata, hready, hresp    : AHB read data / ready (always 1) / resp (always OKAY)
//   tx                       : serial output, idle high
module ahb_uart_tx #(
   parameter logic [31:0] START_ADDR = 32'h8003_0000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   input  logic        hwrite,
   input  logic        hsel,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic        hmastlock,
   output logic        hready,
   output logic        hresp,
   output logic        tx
);

   localparam int unsigned PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]  DEPTH5 = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // ---------------- AHB address phase capture ----------------
   logic        w_valid;
   logic [31:0] w_off_full;
   logic        r_dp_valid;
   logic        r_dp_write;
   logic [1:0]  r_dp_off;

   assign w_valid    = hsel & htrans[1];
   assign w_off_full = haddr - START_ADDR;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_off   <= 2'd0;
      end else begin
         r_dp_valid <= w_valid;
         r_dp_write <= hwrite;
         r_dp_off   <= w_off_full[3:2];
      end
   end

   logic w_wr_data;
   logic w_wr_baud;
   logic w_rd_status;

   assign w_wr_data   = r_dp_valid &  r_dp_write & (r_dp_off == 2'd0);
   assign w_wr_baud   = r_dp_valid &  r_dp_write & (r_dp_off == 2'd2);
   assign w_rd_status = r_dp_valid & ~r_dp_write & (r_dp_off == 2'd1);

   // ---------------- Transmit FIFO ----------------
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [4:0]    r_count;
   logic          r_ovf;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_ovf_set;

   assign w_full    = (r_count == DEPTH5);
   assign w_empty   = (r_count == 5'd0);
   // A pop in the same cycle frees a slot, so a push while full is still taken.
   assign w_push    = w_wr_data & (~w_full | w_pop);
   assign w_ovf_set = w_wr_data & w_full & ~w_pop;

   always_ff @(posedge HCLK) begin
      if (w_push) begin
         r_mem[r_wptr] <= hwdata[7:0];
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 5'd0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
         // Set has priority over the read-to-clear of STATUS.
         if (w_ovf_set)        r_ovf <= 1'b1;
         else if (w_rd_status) r_ovf <= 1'b0;
      end
   end

   // ---------------- BAUD register ----------------
   logic [15:0] r_baud;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_baud <= DIV_RESET;
      end else if (w_wr_baud) begin
         r_baud <= (hwdata[15:0] < 16'd2) ? 16'd2 : hwdata[15:0];
      end
   end

   // ---------------- Shifter FSM ----------------
   state_e      r_state;
   state_e      w_state_nxt;
   logic [7:0]  r_shift;
   logic [7:0]  w_shift_nxt;
   logic [2:0]  r_bit_idx;
   logic [2:0]  w_bit_idx_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [15:0] r_baud_lat;
   logic [15:0] w_baud_lat_nxt;
   logic        w_tx;
   logic        w_busy;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= StIdle;
         r_shift    <= 8'd0;
         r_bit_idx  <= 3'd0;
         r_cnt      <= 16'd0;
         r_baud_lat <= DIV_RESET;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_cnt      <= w_cnt_nxt;
         r_baud_lat <= w_baud_lat_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_idx_nxt  = r_bit_idx;
      w_cnt_nxt      = r_cnt;
      w_baud_lat_nxt = r_baud_lat;
      w_pop          = 1'b0;
      w_tx           = 1'b1;

      // Bit-period countdown runs in every non-idle state.
      if (r_state != StIdle && r_cnt != 16'd0) begin
         w_cnt_nxt = r_cnt - 16'd1;
      end

      unique case (r_state)
         StIdle: begin
            w_tx = 1'b1;
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_shift_nxt    = r_mem[r_rptr];
               w_baud_lat_nxt = r_baud;
               w_cnt_nxt      = r_baud - 16'd1;
               w_state_nxt    = StStart;
            end
         end
         StStart: begin
            w_tx = 1'b0;
            if (r_cnt == 16'd0) begin
               w_cnt_nxt     = r_baud_lat - 16'd1;
               w_bit_idx_nxt = 3'd0;
               w_state_nxt   = StData;
            end
         end
         StData: begin
            w_tx = r_shift[r_bit_idx];
            if (r_cnt == 16'd0) begin
               w_cnt_nxt = r_baud_lat - 16'd1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = StStop;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         StStop: begin
            w_tx = 1'b1;
            if (r_cnt == 16'd0) begin
               if (!w_empty) begin
                  // Back-to-back frame: no idle gap after the stop bit.
                  w_pop          = 1'b1;
                  w_shift_nxt    = r_mem[r_rptr];
                  w_baud_lat_nxt = r_baud;
                  w_cnt_nxt      = r_baud - 16'd1;
                  w_state_nxt    = StStart;
               end else begin
                  w_state_nxt = StIdle;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign w_busy = (r_state != StIdle);
   assign tx     = w_tx;

   // ---------------- AHB read data / response ----------------
   always_comb begin
      hrdata = 32'd0;
      if (r_dp_valid && !r_dp_write) begin
         unique case (r_dp_off)
            2'd1:    hrdata = {23'd0, r_count, r_ovf, w_busy, w_empty, w_full};
            2'd2:    hrdata = {16'd0, r_baud};
            default: hrdata = 32'd0;
         endcase
      end
   end

   assign hready = 1'b1;
   assign hresp  = 1'b0;

   logic w_unused;
   assign w_unused = ^{hsize, hburst, hprot, hmastlock, htrans[0], hwdata[31:16],
                       w_off_full[31:4], w_off_full[1:0]};

endmodule
